rr_mux4_arbiter: RTL and testbench

RR_MUX4_ARBITER -- requirements
Module: rr_mux4_arbiter

---
 rtl/arb_pkg.sv | 12 +
 rtl/mux4.sv | 24 ++
 rtl/rr_mux4_arbiter.sv | 111 +++++++++++
 tb/tb_rr_mux4_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin mux4 arbiter: output-register
// state encoding and the number of requesters.
package arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mux4.sv
// Plain 4:1 word multiplexer, selected by a 2-bit index.
module mux4 #(
  parameter int N = 8
) (
  input  logic [1:0]   sel,
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic [N-1:0] in3,
  output logic [N-1:0] out
);

  // Route the selected requester word to the output.
  always_comb begin
    out = in0;
    case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter over four requesters feeding a single registered
// output slot. Arbitration uses a rotating pointer that moves one past the
// last winner, so a requester held valid is served within four loads.
//
// Handshake: a word moves on a cycle where valid and ready are both high.
// Upstream, in_ready is one-hot at the winner only when the output slot is
// empty or being drained this cycle; it never depends on in_ready itself.
// Downstream, out_valid stays high with out_data stable until out_ready.
module rr_mux4_arbiter
  import arb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   in_valid,
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic [N-1:0] in3,
  output logic [3:0]   in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_src,
  output logic         dbg_state,
  output logic [1:0]   dbg_ptr
);

  arb_state_e   state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [N-1:0] data_q, data_d;
  logic [1:0]   src_q, src_d;

  logic         load;
  logic [1:0]   win_idx;
  logic [1:0]   cand;
  logic         found;
  logic [N-1:0] mux_word;

  assign out_valid = (state_q == S_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

  // Gating with rst keeps in_ready low while the block is held in reset.
  assign load = rst && (|in_valid) && (!out_valid || out_ready);

  // Circular priority search starting at ptr: first valid requester wins.
  always_comb begin
    win_idx = ptr_q;
    cand    = ptr_q;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && in_valid[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

  // Grant is one-hot at the winner, only on a load cycle.
  always_comb begin
    in_ready = 4'b0000;
    if (load) in_ready = 4'b0001 << win_idx;
  end

  mux4 #(.N(N)) u_mux4 (
    .sel (win_idx),
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .out (mux_word)
  );

  // Next-state: load replaces the slot (even while draining), a drain with
  // no new word empties it, a stall holds everything.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    src_d   = src_q;
    if (load) begin
      state_d = S_FULL;
      ptr_d   = win_idx + 2'd1;
      data_d  = mux_word;
      src_d   = win_idx;
    end else if (state_q == S_FULL && out_ready) begin
      state_d = S_EMPTY;
    end
  end

  // State and output registers; reset discards any held word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      ptr_q   <= 2'd0;
      data_q  <= '0;
      src_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed testbench for rr_mux4_arbiter with hand-computed expectations.
module tb_rr_mux4_arbiter;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [3:0]   in_valid;
  logic [N-1:0] in0, in1, in2, in3;
  logic [3:0]   in_ready;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_src;
  logic         dbg_state;
  logic [1:0]   dbg_ptr;

  int n_checks = 0;
  int n_pass   = 0;

  rr_mux4_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    in0 = 8'h00; in1 = 8'h00; in2 = 8'h00; in3 = 8'h00;
    step(); step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'h00) $display("FAIL reset_data: got %h want 00", out_data); else n_pass++;
    n_checks++; if (out_src !== 2'd0) $display("FAIL reset_src: got %0d want 0", out_src); else n_pass++;
    n_checks++; if (dbg_ptr !== 2'd0) $display("FAIL reset_ptr: got %0d want 0", dbg_ptr); else n_pass++;
    n_checks++; if (in_ready !== 4'b0000) $display("FAIL reset_in_ready: got %b want 0000", in_ready); else n_pass++;
    in_valid = 4'b0000;
    #4 rst = 1'b1;  // release mid-cycle, away from the edge
  endtask

  task automatic test_single_grant();
    in_valid = 4'b0100; in2 = 8'hA5; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 4'b0100) $display("FAIL single_in_ready: got %b want 0100", in_ready); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'hA5) $display("FAIL single_data: got %h want a5", out_data); else n_pass++;
    n_checks++; if (out_src !== 2'd2) $display("FAIL single_src: got %0d want 2", out_src); else n_pass++;
    n_checks++; if (dbg_ptr !== 2'd3) $display("FAIL single_ptr: got %0d want 3", dbg_ptr); else n_pass++;
  endtask

  task automatic test_drain();
    in_valid = 4'b0000; out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL drain_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'hA5) $display("FAIL drain_data_hold: got %h want a5", out_data); else n_pass++;
    n_checks++; if (out_src !== 2'd2) $display("FAIL drain_src_hold: got %0d want 2", out_src); else n_pass++;
    n_checks++; if (dbg_ptr !== 2'd3) $display("FAIL drain_ptr_hold: got %0d want 3", dbg_ptr); else n_pass++;
  endtask

  task automatic test_wrap();
    // ptr is 3; only requester 1 is valid, so the search wraps 3,0,1.
    in_valid = 4'b0010; in1 = 8'h11; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 4'b0010) $display("FAIL wrap_in_ready: got %b want 0010", in_ready); else n_pass++;
    step();
    n_checks++; if (out_src !== 2'd1) $display("FAIL wrap_src: got %0d want 1", out_src); else n_pass++;
    n_checks++; if (out_data !== 8'h11) $display("FAIL wrap_data: got %h want 11", out_data); else n_pass++;
    n_checks++; if (dbg_ptr !== 2'd2) $display("FAIL wrap_ptr: got %0d want 2", dbg_ptr); else n_pass++;
    in_valid = 4'b0000;
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_rdy;
    // Fresh reset so the pointer starts at requester 0.
    #2 rst = 1'b0;
    #3 rst = 1'b1;
    in0 = 8'd1; in1 = 8'd2; in2 = 8'd3; in3 = 8'd4;
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_rdy = 4'b0001 << (k % 4);
      #1;
      n_checks++; if (in_ready !== exp_rdy) $display("FAIL b2b_in_ready[%0d]: got %b want %b", k, in_ready, exp_rdy); else n_pass++;
      step();
      n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", k, out_valid); else n_pass++;
      n_checks++; if (out_src !== 2'(k % 4)) $display("FAIL b2b_src[%0d]: got %0d want %0d", k, out_src, k % 4); else n_pass++;
      n_checks++; if (out_data !== 8'((k % 4) + 1)) $display("FAIL b2b_data[%0d]: got %0d want %0d", k, out_data, (k % 4) + 1); else n_pass++;
    end
  endtask

  task automatic test_stall();
    // Slot holds word 4 from requester 3; consumer stalls for 3 cycles.
    out_ready = 1'b0; in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      in0 = 8'(8'h50 + k);  // non-granted input churn must not leak in
      #1;
      n_checks++; if (in_ready !== 4'b0000) $display("FAIL stall_in_ready[%0d]: got %b want 0000", k, in_ready); else n_pass++;
      step();
      n_checks++; if (out_data !== 8'd4) $display("FAIL stall_data[%0d]: got %0d want 4", k, out_data); else n_pass++;
      n_checks++; if (out_valid !== 1'b1 || out_src !== 2'd3) $display("FAIL stall_hold[%0d]: got v=%b src=%0d want v=1 src=3", k, out_valid, out_src); else n_pass++;
    end
    in0 = 8'd1; out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 4'b0001) $display("FAIL release_in_ready: got %b want 0001", in_ready); else n_pass++;
    step();
    n_checks++; if (out_src !== 2'd0) $display("FAIL release_src: got %0d want 0", out_src); else n_pass++;
    n_checks++; if (out_data !== 8'd1) $display("FAIL release_data: got %0d want 1", out_data); else n_pass++;
  endtask

  task automatic test_midstream_reset();
    // ptr is 1; only requester 3 valid -> load word 4, then stall.
    in_valid = 4'b1000; out_ready = 1'b1;
    step();
    n_checks++; if (out_data !== 8'h04 || out_src !== 2'd3) $display("FAIL pre_reset_load: got data=%h src=%0d want 04/3", out_data, out_src); else n_pass++;
    out_ready = 1'b0; in_valid = 4'b1111;
    #2 rst = 1'b0;
    #1;  // no clock edge since reset asserted
    n_checks++; if (out_valid !== 1'b0) $display("FAIL async_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'h00) $display("FAIL async_data: got %h want 00", out_data); else n_pass++;
    n_checks++; if (out_src !== 2'd0) $display("FAIL async_src: got %0d want 0", out_src); else n_pass++;
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 4'b0000) $display("FAIL async_in_ready: got %b want 0000", in_ready); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 4'b0001) $display("FAIL post_reset_in_ready: got %b want 0001", in_ready); else n_pass++;
    step();
    n_checks++; if (out_src !== 2'd0 || out_data !== 8'd1) $display("FAIL post_reset_grant: got src=%0d data=%0d want 0/1", out_src, out_data); else n_pass++;
    in_valid = 4'b0000;
    step();
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_single_grant();
    test_drain();
    test_wrap();
    test_back_to_back();
    test_stall();
    test_midstream_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
